// File: rtl/neopixel_rx.sv
// -----------------------------------------------------------------------------
// neopixel_rx
//
// Receive side of the WS2812-style one-wire NRZ pixel protocol. The line is
// brought into the clk domain through a two-flop synchronizer plus one
// history flop for edge detection. Each high pulse is timed: pulses at or
// above BIT_THRESHOLD cycles decode as 1, shorter ones as 0. Bits are
// assembled MSB-first into 24-bit words, and a low stretch of RESET_CYCLES
// (the latch gap) closes the frame.
//
// After reset, or after a line fault, the decoder waits for one full latch
// gap before it accepts data. That way it never locks onto a frame partway
// through.
//
// Parameters:
//   BIT_THRESHOLD  high-pulse length (cycles) at or above which a bit is 1
//   RESET_CYCLES   continuous low cycles forming a latch gap
//   MAX_HIGH       high-pulse length (cycles) treated as a line fault (<=255)
//
// Ports:
//   clk          in   system clock (32 MHz)
//   reset_n      in   asynchronous active-low reset
//   one_wire     in   asynchronous serial data line
//   color        out  last complete word, first-received bit in bit 23
//   color_valid  out  one-cycle strobe when color is updated
//   word_index   out  index of the presented word within its frame (sat. 255)
//   frame_done   out  one-cycle strobe at a gap closing a frame with >=1 word
//   error        out  one-cycle strobe on over-long high or partial word
//   busy         out  high from a frame's first accepted rise to its end/fault
// -----------------------------------------------------------------------------
module neopixel_rx #(
  parameter int BIT_THRESHOLD = 19,
  parameter int RESET_CYCLES  = 1600,
  parameter int MAX_HIGH      = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        one_wire,
  output logic [23:0] color,
  output logic        color_valid,
  output logic [7:0]  word_index,
  output logic        frame_done,
  output logic        error,
  output logic        busy
);

  localparam int LW = $clog2(RESET_CYCLES + 1);

  typedef logic [LW-1:0] lcnt_t;

  localparam lcnt_t      LCNT_MAX  = lcnt_t'(RESET_CYCLES);
  localparam logic [7:0] HCNT_MAX  = 8'(MAX_HIGH);
  localparam logic [7:0] THRESHOLD = 8'(BIT_THRESHOLD);

  typedef enum logic [1:0] {
    SYNC,   // waiting for a full latch gap before trusting the line
    IDLE,   // between frames, waiting for the first rise
    HIGH,   // timing a high pulse
    LOW     // timing the low after a bit
  } state_t;

  state_t      state;
  logic        s1, s2, s3;
  logic [7:0]  hcnt;
  lcnt_t       lcnt;
  logic [4:0]  bitcnt;
  logic [23:0] shreg;
  logic [7:0]  wcnt;       // words completed in the current frame
  logic        word_pend;  // 24th bit shifted; present the word next cycle

  logic       rise, fall;
  logic [7:0] hcnt_next;
  lcnt_t      lcnt_next;
  logic       bit_val;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // The count including the current cycle, so a pulse of N high cycles
  // measures exactly N when its fall is seen.
  assign hcnt_next = (hcnt == 8'hFF) ? hcnt : hcnt + 8'd1;
  assign lcnt_next = (lcnt == LCNT_MAX) ? lcnt : lcnt + lcnt_t'(1);
  assign bit_val   = (hcnt_next >= THRESHOLD);

  // Synchronizer and edge-history flops.
  // NOTE: every clocked register uses non-blocking (<=) assignments so that all
  // flops sample their inputs at the same instant. Blocking assignments here
  // would collapse s1/s2/s3 into a single stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= one_wire;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC;
      hcnt        <= '0;
      lcnt        <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      wcnt        <= '0;
      word_pend   <= 1'b0;
      color       <= '0;
      color_valid <= 1'b0;
      word_index  <= '0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // NOTE: the strobes are cleared first on every clock. A later assignment
      // in the same cycle overrides this one, so each strobe lasts exactly one
      // cycle without any explicit "clear next cycle" logic.
      color_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      // Word presentation. This runs one cycle after the completing fall, which
      // keeps the fall-to-strobe latency aligned with the gap and fault paths.
      // The state machine below never changes wcnt or shreg in this cycle,
      // because the line is guaranteed low for at least one more cycle.
      if (word_pend) begin
        word_pend   <= 1'b0;
        color       <= shreg;
        color_valid <= 1'b1;
        word_index  <= wcnt;
        if (wcnt != 8'hFF) wcnt <= wcnt + 8'd1;
      end

      unique case (state)
        SYNC: begin
          if (s2) begin
            lcnt <= '0;
          end else if (lcnt == LCNT_MAX) begin
            state <= IDLE;
          end else begin
            lcnt <= lcnt_next;
          end
        end

        IDLE: begin
          if (rise) begin
            state <= HIGH;
            hcnt  <= '0;
            busy  <= 1'b1;
          end
        end

        HIGH: begin
          if (hcnt == HCNT_MAX) begin
            // The line has been stuck high: abandon the frame and resynchronize.
            error  <= 1'b1;
            shreg  <= '0;
            bitcnt <= '0;
            wcnt   <= '0;
            busy   <= 1'b0;
            lcnt   <= '0;
            state  <= SYNC;
          end else if (fall) begin
            shreg <= {shreg[22:0], bit_val};
            lcnt  <= '0;
            state <= LOW;
            if (bitcnt == 5'd23) begin
              bitcnt    <= '0;
              word_pend <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 5'd1;
            end
          end else begin
            hcnt <= hcnt_next;
          end
        end

        LOW: begin
          if (lcnt == LCNT_MAX) begin
            // Latch gap: close the frame. A partial word is reported and dropped.
            error      <= (bitcnt != 5'd0);
            frame_done <= (wcnt != 8'd0);
            wcnt       <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            if (rise) begin
              // The next frame starts on the very cycle the gap completes.
              state <= HIGH;
              hcnt  <= '0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (rise) begin
            state <= HIGH;
            hcnt  <= '0;
          end else begin
            lcnt <= lcnt_next;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_rx.sv
// -----------------------------------------------------------------------------
// tb_neopixel_rx
//
// Directed bench for neopixel_rx at its default parameters. The line is driven
// on falling clock edges. A falling-edge monitor logs every strobe together
// with the cycle on which it was seen, and the directed steps compare that
// log against values computed by hand.
//
// Latency reference: when the line changes at the negedge where cyc == k, the
// DUT first samples the change at posedge k+1. A strobe due d cycles after
// that sample is logged with cyc == k + 1 + d.
// -----------------------------------------------------------------------------
module tb_neopixel_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        one_wire;
  logic [23:0] color;
  logic        color_valid;
  logic [7:0]  word_index;
  logic        frame_done;
  logic        error;
  logic        busy;

  neopixel_rx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .one_wire   (one_wire),
    .color      (color),
    .color_valid(color_valid),
    .word_index (word_index),
    .frame_done (frame_done),
    .error      (error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log.
  logic [23:0] cv_color[$];
  logic [7:0]  cv_idx[$];
  int          cv_cyc[$];
  int          fd_cyc[$];
  int          err_cyc[$];
  int          busy_falls = 0;
  logic        busy_q = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (color_valid) begin
        cv_color.push_back(color);
        cv_idx.push_back(word_index);
        cv_cyc.push_back(cyc);
      end
      if (frame_done) fd_cyc.push_back(cyc);
      if (error)      err_cyc.push_back(cyc);
      if (busy_q && !busy) busy_falls++;
      busy_q = busy;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int last_fall = 0;
  int rise_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    cv_color.delete();
    cv_idx.delete();
    cv_cyc.delete();
    fd_cyc.delete();
    err_cyc.delete();
    busy_falls = 0;
  endtask

  task automatic idle(input int n);
    one_wire = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_hl(input int h, input int l);
    one_wire = 1'b1;
    repeat (h) @(negedge clk);
    one_wire = 1'b0;
    last_fall = cyc;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_hl(26, 14);
    else   send_hl(13, 27);
  endtask

  // Send bits [23 .. 24-n] of w, MSB first.
  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".color"},       32'(color),       32'h0);
    check({tag, ".color_valid"}, 32'(color_valid), 32'h0);
    check({tag, ".word_index"},  32'(word_index),  32'h0);
    check({tag, ".frame_done"},  32'(frame_done),  32'h0);
    check({tag, ".error"},       32'(error),       32'h0);
    check({tag, ".busy"},        32'(busy),        32'h0);
  endtask

  initial begin
    reset_n  = 1'b0;
    one_wire = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // ---- 1: single word after the initial sync gap ----
    idle(1620);
    clear_log();
    send_bits(24'h1E0000, 24);
    idle(2000);
    check("t1.cv_count", 32'(cv_color.size()), 32'd1);
    if (cv_color.size() == 1) begin
      check("t1.color",      32'(cv_color[0]),          32'h1E0000);
      check("t1.word_index", 32'(cv_idx[0]),            32'd0);
      check("t1.cv_latency", 32'(cv_cyc[0] - last_fall), 32'd4);
    end
    check("t1.fd_count", 32'(fd_cyc.size()), 32'd1);
    if (fd_cyc.size() == 1)
      check("t1.fd_latency", 32'(fd_cyc[0] - last_fall), 32'd1604);
    check("t1.err_count", 32'(err_cyc.size()), 32'd0);
    check("t1.busy_after", 32'(busy), 32'd0);

    // ---- 2: three words back to back ----
    clear_log();
    send_bits(24'h00001E, 24);
    send_bits(24'h001E00, 24);
    send_bits(24'h1E0000, 24);
    check("t2.busy_mid", 32'(busy), 32'd1);
    check("t2.busy_falls_mid", 32'(busy_falls), 32'd0);
    idle(2000);
    check("t2.cv_count", 32'(cv_color.size()), 32'd3);
    if (cv_color.size() == 3) begin
      check("t2.color0", 32'(cv_color[0]), 32'h00001E);
      check("t2.color1", 32'(cv_color[1]), 32'h001E00);
      check("t2.color2", 32'(cv_color[2]), 32'h1E0000);
      check("t2.idx0",   32'(cv_idx[0]),   32'd0);
      check("t2.idx1",   32'(cv_idx[1]),   32'd1);
      check("t2.idx2",   32'(cv_idx[2]),   32'd2);
    end
    check("t2.fd_count", 32'(fd_cyc.size()), 32'd1);
    check("t2.busy_falls_end", 32'(busy_falls), 32'd1);
    check("t2.err_count", 32'(err_cyc.size()), 32'd0);

    // ---- 3: threshold boundary, 18-cycle highs then 19-cycle highs ----
    clear_log();
    for (int i = 0; i < 24; i++) send_hl(18, 22);
    for (int i = 0; i < 24; i++) send_hl(19, 21);
    idle(2000);
    check("t3.cv_count", 32'(cv_color.size()), 32'd2);
    if (cv_color.size() == 2) begin
      check("t3.color18", 32'(cv_color[0]), 32'h000000);
      check("t3.color19", 32'(cv_color[1]), 32'hFFFFFF);
      check("t3.idx1",    32'(cv_idx[1]),   32'd1);
    end
    check("t3.err_count", 32'(err_cyc.size()), 32'd0);

    // ---- 4: data before any sync gap is ignored ----
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    idle(100);
    send_bits(24'h1E0000, 24);
    idle(1700);
    check("t4.nosync_cv",  32'(cv_color.size()), 32'd0);
    check("t4.nosync_fd",  32'(fd_cyc.size()),   32'd0);
    check("t4.nosync_err", 32'(err_cyc.size()),  32'd0);
    send_bits(24'h1E0000, 24);
    idle(2000);
    check("t4.cv_count", 32'(cv_color.size()), 32'd1);
    if (cv_color.size() == 1)
      check("t4.color", 32'(cv_color[0]), 32'h1E0000);
    check("t4.fd_count", 32'(fd_cyc.size()), 32'd1);

    // ---- 5: partial word at a gap, then a stuck-high fault ----
    clear_log();
    send_bits(24'hA5A5A5, 12);
    idle(2000);
    check("t5.partial_err", 32'(err_cyc.size()),  32'd1);
    if (err_cyc.size() == 1)
      check("t5.partial_err_latency", 32'(err_cyc[0] - last_fall), 32'd1604);
    check("t5.partial_cv", 32'(cv_color.size()), 32'd0);
    check("t5.partial_fd", 32'(fd_cyc.size()),   32'd0);

    clear_log();
    one_wire = 1'b1;
    rise_cyc = cyc;
    repeat (100) @(negedge clk);
    one_wire = 1'b0;
    check("t5.fault_err", 32'(err_cyc.size()), 32'd1);
    if (err_cyc.size() == 1)
      check("t5.fault_latency", 32'(err_cyc[0] - rise_cyc), 32'd68);
    check("t5.fault_busy", 32'(busy), 32'd0);
    idle(1700);
    clear_log();
    send_bits(24'hA5C33C, 24);
    idle(2000);
    check("t5.recover_cv", 32'(cv_color.size()), 32'd1);
    if (cv_color.size() == 1) begin
      check("t5.recover_color", 32'(cv_color[0]), 32'hA5C33C);
      check("t5.recover_idx",   32'(cv_idx[0]),   32'd0);
    end
    check("t5.recover_err", 32'(err_cyc.size()), 32'd0);

    // ---- 6: reset in the middle of a word ----
    clear_log();
    send_bits(24'h1E0000, 10);
    check("t6.busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6.in_reset");
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 13; i >= 0; i--) send_bit(i == 12);
    idle(2000);
    check("t6.cv",    32'(cv_color.size()), 32'd0);
    check("t6.err",   32'(err_cyc.size()),  32'd0);
    check("t6.fd",    32'(fd_cyc.size()),   32'd0);
    check("t6.color", 32'(color),           32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #5ms;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
